// File: rtl/connect4_board_ctrl_if.sv
// Move handshake, board state and winner-detector status for the 4x4 connect-4 controller.
interface connect4_board_ctrl_if;
  logic        new_game;
  logic        move_valid;
  logic [1:0]  move_col;
  logic        move_ready;
  logic [1:0]  game_status;
  logic [15:0] game_board;
  logic [15:0] player_cells;
  logic        current_player;
  logic        move_accepted;
  logic        move_rejected;
  logic [4:0]  move_count;
  logic        game_over;

  modport master (
    output new_game, move_valid, move_col, game_status,
    input  move_ready, game_board, player_cells, current_player,
           move_accepted, move_rejected, move_count, game_over
  );

  modport slave (
    input  new_game, move_valid, move_col, game_status,
    output move_ready, game_board, player_cells, current_player,
           move_accepted, move_rejected, move_count, game_over
  );
endinterface

// File: rtl/connect4_board_ctrl.sv
// 4x4 connect-4 board controller: drops a piece into a column by scanning upward,
// then waits for the external winner detector before handing the turn over.
module connect4_board_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FIRST_PLAYER  = 0
) (
  input logic                  clk,
  input logic                  reset,
  connect4_board_ctrl_if.slave bus
);
  // state    | meaning
  // IDLE     | waiting for a move handshake
  // SCAN     | climbing the latched column one row per cycle
  // SETTLE   | giving game_status time to reflect the new piece
  // GAMEOVER | win or tie reported; only new_game or reset leave
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SCAN     = 2'd1;
  localparam logic [1:0] SETTLE   = 2'd2;
  localparam logic [1:0] GAMEOVER = 2'd3;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic       FIRST_P     = 1'(FIRST_PLAYER);

  logic [1:0]  r_state;
  logic [1:0]  r_col;
  logic [1:0]  r_row;
  logic [3:0]  r_settle;
  logic [15:0] r_board;
  logic [15:0] r_cells;
  logic        r_player;
  logic        r_acc;
  logic        r_rej;
  logic [4:0]  r_count;

  logic [3:0]  w_idx;
  logic        w_cell_full;

  assign w_idx       = {r_row, r_col};
  assign w_cell_full = r_board[w_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_col    <= 2'd0;
      r_row    <= 2'd0;
      r_settle <= 4'd0;
      r_board  <= 16'd0;
      r_cells  <= 16'd0;
      r_player <= FIRST_P;
      r_acc    <= 1'b0;
      r_rej    <= 1'b0;
      r_count  <= 5'd0;
    end else if (bus.new_game) begin
      r_state  <= IDLE;
      r_col    <= 2'd0;
      r_row    <= 2'd0;
      r_settle <= 4'd0;
      r_board  <= 16'd0;
      r_cells  <= 16'd0;
      r_player <= FIRST_P;
      r_acc    <= 1'b0;
      r_rej    <= 1'b0;
      r_count  <= 5'd0;
    end else begin
      r_acc <= 1'b0;
      r_rej <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.move_valid) begin
            r_col   <= bus.move_col;
            r_row   <= 2'd0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (!w_cell_full) begin
            r_board[w_idx] <= 1'b1;
            r_cells[w_idx] <= r_player;
            if (r_count != 5'd16) r_count <= r_count + 5'd1;
            r_acc    <= 1'b1;
            r_settle <= SETTLE_LOAD;
            r_state  <= SETTLE;
          end else if (r_row != 2'd3) begin
            r_row <= r_row + 2'd1;
          end else begin
            r_rej   <= 1'b1;
            r_state <= IDLE;
          end
        end
        SETTLE: begin
          // terminal count reached: this edge is the single status sample
          if (r_settle <= 4'd1) begin
            if (bus.game_status == 2'b00) begin
              r_player <= ~r_player;
              r_state  <= IDLE;
            end else begin
              r_state <= GAMEOVER;
            end
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        GAMEOVER: r_state <= GAMEOVER;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign bus.move_ready     = (r_state == IDLE);
  assign bus.game_over      = (r_state == GAMEOVER);
  assign bus.game_board     = r_board;
  assign bus.player_cells   = r_cells;
  assign bus.current_player = r_player;
  assign bus.move_accepted  = r_acc;
  assign bus.move_rejected  = r_rej;
  assign bus.move_count     = r_count;
endmodule

// File: tb/tb_connect4_board_ctrl.sv
// Bench for connect4_board_ctrl: column-height board model with event-time scheduling,
// per-cycle output compare, directed scenarios with literal expectations, random play.
module tb_connect4_board_ctrl;
  localparam int S  = 2;
  localparam int FP = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  connect4_board_ctrl_if bus();
  connect4_board_ctrl #(.SETTLE_CYCLES(S), .FIRST_PLAYER(FP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Board model: per-column fill height and owner of each stacked piece
  int height[4];
  bit owner[4][4];
  bit m_player, m_busy, m_over, m_acc, m_rej;
  int m_count, m_col, ev_cyc, ev_kind;  // ev_kind: 0 place, 1 reject, 2 status decision

  function automatic logic [15:0] m_board();
    logic [15:0] b = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (r < height[c]) b[r*4+c] = 1'b1;
    return b;
  endfunction

  function automatic logic [15:0] m_cells();
    logic [15:0] p = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (r < height[c]) p[r*4+c] = owner[c][r];
    return p;
  endfunction

  function automatic logic [1:0] detect();
    logic [15:0] b = m_board();
    logic [15:0] p2 = b & m_cells();
    logic [15:0] p1 = b & ~m_cells();
    logic [15:0] lines[10];
    logic [1:0] res = 2'b00;
    for (int i = 0; i < 4; i++) begin
      lines[i]   = 16'h000F << (4*i);
      lines[4+i] = 16'h1111 << i;
    end
    lines[8] = 16'h8421;
    lines[9] = 16'h1248;
    for (int i = 0; i < 10; i++) begin
      if ((p1 & lines[i]) == lines[i]) res = 2'b01;
      else if ((p2 & lines[i]) == lines[i]) res = 2'b10;
    end
    if (res == 2'b00 && b == 16'hFFFF) res = 2'b11;
    return res;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      height[c] = 0;
      for (int r = 0; r < 4; r++) owner[c][r] = 1'b0;
    end
    m_player = (FP != 0);
    m_busy = 0; m_over = 0; m_acc = 0; m_rej = 0; m_count = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset || bus.new_game) begin
      model_clear();
    end else begin
      m_acc = 0;
      m_rej = 0;
      if (m_busy) begin
        if (cyc == ev_cyc) begin
          case (ev_kind)
            0: begin
              owner[m_col][height[m_col]] = m_player;
              height[m_col]++;
              if (m_count < 16) m_count++;
              m_acc = 1;
              ev_kind = 2;
              ev_cyc = cyc + S;
            end
            1: begin
              m_rej = 1;
              m_busy = 0;
            end
            default: begin
              if (bus.game_status == 2'b00) m_player = !m_player;
              else m_over = 1;
              m_busy = 0;
            end
          endcase
        end
      end else if (!m_over && bus.move_valid) begin
        m_col = int'(bus.move_col);
        m_busy = 1;
        if (height[m_col] < 4) begin
          ev_kind = 0;
          ev_cyc = cyc + 1 + height[m_col];
        end else begin
          ev_kind = 1;
          ev_cyc = cyc + 4;
        end
      end
    end
  end

  bit st_auto = 0;
  logic [1:0] st_force = 2'b00;
  always @(posedge clk) begin
    #1;
    bus.game_status = st_auto ? detect() : st_force;
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_board", 32'(bus.game_board), 32'd0);
      chk("rst_cells", 32'(bus.player_cells), 32'd0);
      chk("rst_count", 32'(bus.move_count), 32'd0);
      chk("rst_player", 32'(bus.current_player), 32'(FP));
      chk("rst_acc", 32'(bus.move_accepted), 32'd0);
      chk("rst_rej", 32'(bus.move_rejected), 32'd0);
      chk("rst_over", 32'(bus.game_over), 32'd0);
      chk("rst_ready", 32'(bus.move_ready), 32'd1);
    end else begin
      chk("board", 32'(bus.game_board), 32'(m_board()));
      chk("cells", 32'(bus.player_cells), 32'(m_cells()));
      chk("count", 32'(bus.move_count), 32'(m_count));
      chk("player", 32'(bus.current_player), 32'(m_player));
      chk("accepted", 32'(bus.move_accepted), 32'(m_acc));
      chk("rejected", 32'(bus.move_rejected), 32'(m_rej));
      chk("game_over", 32'(bus.game_over), 32'(m_over));
      chk("ready", 32'(bus.move_ready), 32'(!m_busy && !m_over));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_busy && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) timeout("wait_idle");
  endtask

  task automatic do_move(input int col, output int hs);
    wait_idle();
    if (m_over) timeout("move_while_over");
    bus.move_valid = 1'b1;
    bus.move_col = 2'(col);
    tick();
    hs = cyc;
    bus.move_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int hs, output int lat, output bit acc);
    lat = -1;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.move_accepted || bus.move_rejected) begin
        lat = cyc - hs;
        acc = bus.move_accepted;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_over();
    int k = 0;
    while (!m_over && k < 30) begin
      tick();
      k++;
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_board"}, 32'(bus.game_board), 32'd0);
    chk({tag, "_count"}, 32'(bus.move_count), 32'd0);
    chk({tag, "_player"}, 32'(bus.current_player), 32'(FP));
    chk({tag, "_ready"}, 32'(bus.move_ready), 32'd1);
    chk({tag, "_pulse"}, 32'({bus.move_accepted, bus.move_rejected}), 32'd0);
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
  endtask

  int hs, lat;
  bit acc;
  int exp_lat[5] = '{1, 2, 3, 4, 4};
  int seq37[7] = '{0, 1, 0, 1, 0, 1, 0};

  initial begin
    bus.new_game = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_col = 2'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_cleared("after_reset");

    // single drop in column 2
    do_move(2, hs);
    wait_pulse(hs, lat, acc);
    chk("c2_latency", 32'(lat), 32'd1);
    chk("c2_accepted", 32'(acc), 32'd1);
    chk("c2_board", 32'(bus.game_board), 32'h0004);
    chk("c2_cells", 32'(bus.player_cells), 32'h0000);
    wait_idle();
    chk("c2_player", 32'(bus.current_player), 32'd1);
    chk("c2_count", 32'(bus.move_count), 32'd1);

    // five drops in column 1
    pulse_new_game();
    for (int i = 0; i < 5; i++) begin
      do_move(1, hs);
      wait_pulse(hs, lat, acc);
      chk("c1_latency", 32'(lat), 32'(exp_lat[i]));
      chk("c1_accepted", 32'(acc), 32'(i < 4));
      wait_idle();
    end
    chk("c1_board", 32'(bus.game_board), 32'h2222);
    chk("c1_cells", 32'(bus.player_cells), 32'h2020);
    chk("c1_player", 32'(bus.current_player), 32'd0);

    // P1 wins in column 0 using the bench detector
    pulse_new_game();
    st_auto = 1;
    for (int i = 0; i < 7; i++) begin
      do_move(seq37[i], hs);
      wait_pulse(hs, lat, acc);
    end
    wait_over();
    chk("win_status", 32'(bus.game_status), 32'h1);
    chk("win_over", 32'(bus.game_over), 32'd1);
    chk("win_ready", 32'(bus.move_ready), 32'd0);
    bus.move_valid = 1'b1;
    bus.move_col = 2'd2;
    repeat (5) tick();
    bus.move_valid = 1'b0;
    chk("win_board", 32'(bus.game_board), 32'h1333);
    chk("win_cells", 32'(bus.player_cells), 32'h0222);

    // new_game while in GAMEOVER, then while in SETTLE
    pulse_new_game();
    check_cleared("ng_gameover");
    st_auto = 0;
    st_force = 2'b00;
    do_move(3, hs);
    wait_pulse(hs, lat, acc);
    pulse_new_game();
    check_cleared("ng_settle");

    // fill every cell, tie reported on the last move
    for (int i = 0; i < 16; i++) begin
      if (i == 15) st_force = 2'b11;
      do_move(i % 4, hs);
      wait_pulse(hs, lat, acc);
    end
    wait_over();
    chk("tie_over", 32'(bus.game_over), 32'd1);
    chk("tie_count", 32'(bus.move_count), 32'd16);
    chk("tie_board", 32'(bus.game_board), 32'hFFFF);

    // reset in the middle of scanning column 3
    pulse_new_game();
    st_force = 2'b00;
    for (int i = 0; i < 2; i++) begin
      do_move(3, hs);
      wait_pulse(hs, lat, acc);
    end
    wait_idle();
    do_move(3, hs);
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_cleared("mid_scan_reset");
    do_move(3, hs);
    wait_pulse(hs, lat, acc);
    chk("post_reset_latency", 32'(lat), 32'd1);
    chk("post_reset_board", 32'(bus.game_board), 32'h0008);

    // random play against the model
    st_auto = 1;
    pulse_new_game();
    for (int n = 0; n < 250; n++) begin
      wait_idle();
      if (m_over || $urandom_range(0, 20) == 0) pulse_new_game();
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 15) == 0) begin
        bus.new_game = 1'b1;
        bus.move_valid = 1'b1;
        bus.move_col = 2'($urandom_range(0, 3));
        tick();
        bus.new_game = 1'b0;
        bus.move_valid = 1'b0;
      end else begin
        do_move(int'($urandom_range(0, 3)), hs);
        if ($urandom_range(0, 12) == 0) begin
          repeat ($urandom_range(0, 5)) tick();
          pulse_new_game();
        end
      end
    end
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
